// File: rtl/ram_arb16_if.sv
// Requester-side bus of the RAM arbiter: packed per-requester request fields
// plus the shared completion signals.
interface ram_arb16_if #(
    parameter int NREQ = 3,
    parameter int AW   = 16
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_we;
    logic [2*NREQ-1:0]    req_be;
    logic [AW*NREQ-1:0]   req_addr;
    logic [16*NREQ-1:0]   req_dati;
    logic [NREQ-1:0]      ack;
    logic [15:0]          dato;
    logic                 busy;

    modport master (
        output req, req_we, req_be, req_addr, req_dati,
        input  ack, dato, busy
    );

    modport slave (
        input  req, req_we, req_be, req_addr, req_dati,
        output ack, dato, busy
    );
endinterface

// File: rtl/ram_arb16.sv
// Round-robin arbiter onto RAM port A; byte-enabled writes become a
// read-modify-write because the RAM has no byte lanes.
module ram_arb16 #(
    parameter int NREQ = 3,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    ram_arb16_if.slave    bus,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_dati,
    output logic          ram_we,
    input  logic [15:0]   ram_dato
);
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW1 = IW + 1;

    typedef enum logic [1:0] {IDLE, RD, DAT, WR} state_t;

    state_t          state_q;
    logic [IW-1:0]   last_q, win_q;
    logic            we_q;
    logic [1:0]      be_q;
    logic [15:0]     dati_q;
    logic [NREQ-1:0] ack_q;
    logic [15:0]     dato_q;
    logic [AW-1:0]   ram_addr_q;
    logic [15:0]     ram_dati_q;
    logic            ram_we_q;

    logic            found_d;
    logic [IW-1:0]   win_d;
    logic            sel_we;
    logic [1:0]      sel_be;
    logic [AW-1:0]   sel_addr;
    logic [15:0]     sel_dati;

    // Search starts one past the last winner and wraps modulo NREQ.
    always_comb begin
        logic [IW1-1:0] idx;
        found_d = 1'b0;
        win_d   = '0;
        idx     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = {1'b0, last_q} + IW1'(i);
            if (idx >= IW1'(NREQ)) idx = idx - IW1'(NREQ);
            if (!found_d && bus.req[idx[IW-1:0]]) begin
                found_d = 1'b1;
                win_d   = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_we   = 1'b0;
        sel_be   = '0;
        sel_addr = '0;
        sel_dati = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == win_d) begin
                sel_we   = bus.req_we[i];
                sel_be   = bus.req_be[2*i +: 2];
                sel_addr = bus.req_addr[AW*i +: AW];
                sel_dati = bus.req_dati[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= IW'(NREQ - 1);
            win_q      <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            dati_q     <= '0;
            ack_q      <= '0;
            dato_q     <= '0;
            ram_addr_q <= '0;
            ram_dati_q <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        last_q <= win_d;
                        win_q  <= win_d;
                        we_q   <= sel_we;
                        be_q   <= sel_be;
                        dati_q <= sel_dati;
                        if (sel_we && sel_be == 2'b00) begin
                            ack_q <= NREQ'(1) << win_d;
                        end else if (sel_we && sel_be == 2'b11) begin
                            ram_addr_q <= sel_addr;
                            ram_dati_q <= sel_dati;
                            ram_we_q   <= 1'b1;
                            state_q    <= WR;
                        end else begin
                            ram_addr_q <= sel_addr;
                            ram_we_q   <= 1'b0;
                            state_q    <= RD;
                        end
                    end
                end
                RD: state_q <= DAT;
                DAT: begin
                    if (!we_q) begin
                        dato_q  <= ram_dato;
                        ack_q   <= NREQ'(1) << win_q;
                        state_q <= IDLE;
                    end else begin
                        // Merge the enabled bytes into the word just read.
                        ram_dati_q <= {be_q[1] ? dati_q[15:8] : ram_dato[15:8],
                                       be_q[0] ? dati_q[7:0]  : ram_dato[7:0]};
                        ram_we_q   <= 1'b1;
                        state_q    <= WR;
                    end
                end
                WR: begin
                    ram_we_q <= 1'b0;
                    ack_q    <= NREQ'(1) << win_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack  = ack_q;
    assign bus.dato = dato_q;
    assign bus.busy = (state_q != IDLE);
    assign ram_addr = ram_addr_q;
    assign ram_dati = ram_dati_q;
    assign ram_we   = ram_we_q;
endmodule

// File: tb/tb_ram_arb16.sv
// Bench for ram_arb16: RAM model on port A, per-requester op lists, a
// round-robin reference model feeding a scoreboard drained by a monitor.
module tb_ram_arb16;
    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int MAXOP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arb16_if #(.NREQ(NREQ), .AW(AW)) bus ();
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_dati, ram_dato;
    logic          ram_we;

    ram_arb16 #(.NREQ(NREQ), .AW(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_addr(ram_addr), .ram_dati(ram_dati),
        .ram_we(ram_we), .ram_dato(ram_dato)
    );

    function automatic logic [15:0] init_val(int i);
        return 16'(i * 37) ^ 16'h5A5A;
    endfunction

    // RAM with a loader port standing in for port B.
    logic [15:0] mem [0:65535];
    logic        pb_fill, pb_we;
    logic [15:0] pb_addr, pb_dat;
    always @(posedge clk) begin
        if (pb_fill) for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
        else if (pb_we) mem[pb_addr] <= pb_dat;
        if (ram_we) begin
            mem[ram_addr] <= ram_dati;
            ram_dato      <= ram_dati;
        end else begin
            ram_dato <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int id; bit rd; logic [15:0] data; int lat; int start;} exp_t;
    typedef struct {bit we; logic [1:0] be; logic [15:0] addr; logic [15:0] dati;} op_t;

    exp_t        sbq[$];
    string       dq_nm[$];
    logic [31:0] dq_act[$], dq_exp[$];

    int m_checks = 0, m_fails = 0, we_cnt = 0, last_ack = 0;
    bit prev_we = 1'b0;
    logic [15:0] last_rd = '0;

    // Monitor: owns every comparison and both counters.
    always @(negedge clk) begin
        exp_t e;
        int g;
        while (dq_nm.size() > 0) begin
            string nm;
            logic [31:0] a, x;
            nm = dq_nm.pop_front(); a = dq_act.pop_front(); x = dq_exp.pop_front();
            m_checks++;
            if (a !== x) begin
                m_fails++;
                $display("FAIL %s: got %0h expected %0h", nm, a, x);
            end
        end
        if (rst) begin
            prev_we = 1'b0;
            last_rd = '0;
        end else begin
            if (ram_we) begin
                we_cnt++;
                m_checks++;
                if (prev_we) begin
                    m_fails++;
                    $display("FAIL ram_we_width: high for 2+ cycles at cycle %0d", cyc);
                end
            end
            prev_we = ram_we;
            if (bus.ack != '0) begin
                m_checks++;
                if (!$onehot(bus.ack)) begin
                    m_fails++;
                    $display("FAIL ack_onehot: got %b", bus.ack);
                end
                if (sbq.size() == 0) begin
                    m_checks++; m_fails++;
                    $display("FAIL unexpected_ack: got %b expected none", bus.ack);
                end else begin
                    e = sbq.pop_front();
                    g = (e.start >= 0) ? e.start : last_ack + 1;
                    m_checks++;
                    if (bus.ack !== (NREQ'(1) << e.id)) begin
                        m_fails++;
                        $display("FAIL ack_id: got %b expected requester %0d", bus.ack, e.id);
                    end
                    m_checks++;
                    if (cyc != g + e.lat - 1) begin
                        m_fails++;
                        $display("FAIL ack_latency: got edge %0d expected edge %0d", cyc, g + e.lat - 1);
                    end
                    m_checks++;
                    if (e.rd) begin
                        if (bus.dato !== e.data) begin
                            m_fails++;
                            $display("FAIL read_data: got %h expected %h", bus.dato, e.data);
                        end
                        last_rd = e.data;
                    end else if (bus.dato !== last_rd) begin
                        m_fails++;
                        $display("FAIL dato_hold: got %h expected %h", bus.dato, last_rd);
                    end
                    last_ack = cyc;
                end
            end
        end
    end

    logic [15:0] ref_mem [0:65535];
    int  last_m;
    op_t ops [NREQ][MAXOP];
    int  nops [NREQ];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        dq_nm.push_back(nm); dq_act.push_back(a); dq_exp.push_back(x);
    endtask

    task automatic clr_ops();
        for (int i = 0; i < NREQ; i++) nops[i] = 0;
    endtask

    task automatic add_op(input int r, input bit we, input logic [1:0] be,
                          input logic [15:0] addr, input logic [15:0] dati);
        ops[r][nops[r]] = '{we: we, be: be, addr: addr, dati: dati};
        nops[r]++;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        pb_we = 1'b1; pb_addr = a; pb_dat = v;
        @(negedge clk);
        pb_we = 1'b0;
        ref_mem[a] = v;
    endtask

    // Reference: every requester re-presents immediately, so the grant order
    // is plain round-robin over requesters with ops left.
    task automatic model_batch();
        int p [NREQ];
        int rem, w, idx;
        bit first;
        op_t op;
        exp_t e;
        rem = 0; first = 1'b1;
        for (int i = 0; i < NREQ; i++) begin p[i] = 0; rem += nops[i]; end
        while (rem > 0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (last_m + k) % NREQ;
                if (w < 0 && p[idx] < nops[idx]) w = idx;
            end
            op = ops[w][p[w]];
            p[w]++; rem--; last_m = w;
            e.id = w; e.start = first ? cyc + 1 : -1; first = 1'b0;
            if (!op.we) begin
                e.rd = 1'b1; e.data = ref_mem[op.addr]; e.lat = 3;
            end else begin
                e.rd = 1'b0; e.data = '0;
                e.lat = (op.be == 2'b00) ? 1 : (op.be == 2'b11) ? 2 : 4;
                ref_mem[op.addr] = {op.be[1] ? op.dati[15:8] : ref_mem[op.addr][15:8],
                                    op.be[0] ? op.dati[7:0]  : ref_mem[op.addr][7:0]};
            end
            sbq.push_back(e);
        end
    endtask

    task automatic load_req(input int r, input op_t op);
        bus.req_we[r]            = op.we;
        bus.req_be[2*r +: 2]     = op.be;
        bus.req_addr[AW*r +: AW] = op.addr;
        bus.req_dati[16*r +: 16] = op.dati;
        bus.req[r]               = 1'b1;
    endtask

    // Called right after a negedge; returns busy cycles and ram_addr after E0.
    task automatic run_batch(output int busy_cnt, output logic [15:0] a0);
        int d [NREQ];
        int n;
        busy_cnt = 0; a0 = '0; n = 0;
        model_batch();
        for (int i = 0; i < NREQ; i++) begin
            d[i] = 0;
            if (nops[i] > 0) begin load_req(i, ops[i][0]); d[i] = 1; end
        end
        do begin
            @(negedge clk);
            if (n == 0) a0 = ram_addr;
            if (bus.busy) busy_cnt++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i]) begin
                    if (d[i] < nops[i]) begin load_req(i, ops[i][d[i]]); d[i]++; end
                    else bus.req[i] = 1'b0;
                end
            end
            n++;
        end while ((bus.req != '0 || sbq.size() != 0) && n < 400);
        if (n >= 400) begin
            chk("batch_timeout", 32'd1, 32'd0);
            bus.req = '0;
            sbq.delete();
        end
    endtask

    initial begin
        int bc, w0;
        logic [15:0] a0;
        rst = 1'b1; pb_fill = 1'b0; pb_we = 1'b0; pb_addr = '0; pb_dat = '0;
        bus.req = '0; bus.req_we = '0; bus.req_be = '0; bus.req_addr = '0; bus.req_dati = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        last_m = NREQ - 1;
        @(negedge clk); pb_fill = 1'b1;
        @(negedge clk); pb_fill = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_dato", 32'(bus.dato), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_dati", 32'(ram_dati), 0);
        rst = 1'b0;

        preload(16'h0010, 16'h1234);
        clr_ops(); add_op(0, 0, 2'b00, 16'h0010, 16'h0);
        run_batch(bc, a0);
        chk("rd_ram_addr", 32'(a0), 32'h0010);
        chk("rd_busy_cycles", 32'(bc), 2);
        chk("rd_dato", 32'(bus.dato), 32'h1234);

        w0 = we_cnt;
        clr_ops(); add_op(1, 1, 2'b11, 16'h0020, 16'hBEEF);
        run_batch(bc, a0);
        chk("fw_we_cycles", 32'(we_cnt - w0), 1);
        chk("fw_busy_cycles", 32'(bc), 1);
        clr_ops(); add_op(1, 0, 2'b00, 16'h0020, 16'h0);
        run_batch(bc, a0);
        chk("fw_readback", 32'(bus.dato), 32'hBEEF);

        preload(16'h0030, 16'hAABB);
        clr_ops(); add_op(2, 1, 2'b01, 16'h0030, 16'h1122); add_op(2, 0, 2'b00, 16'h0030, 16'h0);
        run_batch(bc, a0);
        chk("pw_lo_readback", 32'(bus.dato), 32'hAA22);
        preload(16'h0030, 16'hAABB);
        clr_ops(); add_op(2, 1, 2'b10, 16'h0030, 16'h1122); add_op(2, 0, 2'b00, 16'h0030, 16'h0);
        run_batch(bc, a0);
        chk("pw_hi_readback", 32'(bus.dato), 32'h11BB);

        clr_ops();
        for (int r = 0; r < NREQ; r++) begin
            add_op(r, 0, 2'b00, 16'h0010, 16'h0);
            add_op(r, 0, 2'b00, 16'h0020, 16'h0);
        end
        run_batch(bc, a0);

        w0 = we_cnt;
        clr_ops(); add_op(0, 1, 2'b00, 16'h0050, 16'hFFFF);
        run_batch(bc, a0);
        chk("be0_we_cycles", 32'(we_cnt - w0), 0);
        chk("be0_busy_cycles", 32'(bc), 0);
        clr_ops(); add_op(0, 0, 2'b00, 16'h0050, 16'h0);
        run_batch(bc, a0);
        chk("be0_unchanged", 32'(bus.dato), 32'(init_val(16'h0050)));

        // Reset in the DAT cycle of a partial write.
        preload(16'h0040, 16'h5566);
        w0 = we_cnt;
        load_req(0, '{we: 1'b1, be: 2'b01, addr: 16'h0040, dati: 16'h9999});
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        chk("mid_busy_before_rst", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_dato", 32'(bus.dato), 0);
        chk("mid_rst_ram_we", 32'(ram_we), 0);
        rst = 1'b0;
        last_m = NREQ - 1;
        repeat (6) @(negedge clk);
        chk("mid_rst_no_write", 32'(we_cnt - w0), 0);
        clr_ops();
        add_op(1, 0, 2'b00, 16'h0040, 16'h0);
        add_op(0, 0, 2'b00, 16'h0040, 16'h0);
        run_batch(bc, a0);
        chk("mid_rst_mem", 32'(bus.dato), 32'h5566);

        for (int b = 0; b < 40; b++) begin
            clr_ops();
            for (int r = 0; r < NREQ; r++) begin
                int k;
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++)
                    add_op(r, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           16'h0100 + 16'($urandom_range(0, 7)), 16'($urandom));
            end
            run_batch(bc, a0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", m_checks, m_fails);
        $finish;
    end
endmodule
